ttl_74161_chain_sync: RTL and testbench

Clock-enable-driven model of a cascade of 74161 4-bit synchronous binary counters, run entirely on the system clock. An emulated device-clock edge is the rising edge of `Cen` as seen on `Clk`. The block generates the column/row counts and carry strobes that feed the octal latch stages directly downstream. Those latches take `Q` bits or `RCO` as their data or enable inputs.

---
 rtl/ttl_sync_pkg.sv | 7 +
 rtl/ttl_74161_stage.sv | 31 +++
 rtl/ttl_74161_chain_sync.sv | 61 ++++++
 tb/tb_ttl_74161_chain_sync.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ttl_sync_pkg.sv
// Shared constants for the clock-enable-driven 74161 counter models.
package ttl_sync_pkg;

    localparam int unsigned NIB_W = 4;
    localparam logic [NIB_W-1:0] NIB_MAX = 4'hF;

endpackage

// File: rtl/ttl_74161_stage.sv
// One 4-bit 74161 slice: clear > load > count, with a combinational carry-enable out.
module ttl_74161_stage
    import ttl_sync_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             clr,
    input  logic             load,
    input  logic             adv,
    input  logic             t_in,
    input  logic [NIB_W-1:0] d,
    output logic [NIB_W-1:0] q,
    output logic             t_out
);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (adv && t_in) begin
            q <= q + NIB_W'(1);
        end
    end

    // Carry enable into the next stage; follows registered q directly
    assign t_out = t_in && (q == NIB_MAX);

endmodule

// File: rtl/ttl_74161_chain_sync.sv
// Cascade of 74161 counters clocked by Clk, advanced on rising edges of Cen.
module ttl_74161_chain_sync
    import ttl_sync_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      Cen,
    input  logic                      CLRn,
    input  logic                      LOADn,
    input  logic                      ENP,
    input  logic                      ENT,
    input  logic [NIB_W*STAGES-1:0]   D,
    output logic [NIB_W*STAGES-1:0]   Q,
    output logic                      RCO,
    output logic                      TICK
);

    if (STAGES < 1) begin : g_stages_chk
        $error("ttl_74161_chain_sync: STAGES must be >= 1");
    end

    logic              last_cen;
    logic              dev_edge_c;
    logic              load_c;
    logic              adv_c;
    logic [STAGES:0]   t_c;

    // last_cen resets high so a Cen held high through reset is not an edge
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            last_cen <= 1'b1;
            TICK     <= 1'b0;
        end else begin
            last_cen <= Cen;
            TICK     <= CLRn && dev_edge_c;
        end
    end

    assign dev_edge_c = Cen && !last_cen;
    assign load_c     = dev_edge_c && !LOADn;
    assign adv_c      = dev_edge_c && LOADn && ENP;
    assign t_c[0]     = ENT;
    assign RCO        = t_c[STAGES];

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        ttl_74161_stage u_stage (
            .Clk   (Clk),
            .Reset (Reset),
            .clr   (!CLRn),
            .load  (load_c),
            .adv   (adv_c),
            .t_in  (t_c[i]),
            .d     (D[i*NIB_W +: NIB_W]),
            .q     (Q[i*NIB_W +: NIB_W]),
            .t_out (t_c[i+1])
        );
    end

endmodule

// File: tb/tb_ttl_74161_chain_sync.sv
// Scoreboard bench for ttl_74161_chain_sync against an integer counter model.
module tb_ttl_74161_chain_sync;

    localparam int STAGES = 2;
    localparam int W      = 4 * STAGES;
    localparam int MODV   = 1 << W;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         Cen;
    logic         CLRn;
    logic         LOADn;
    logic         ENP;
    logic         ENT;
    logic [W-1:0] D;
    logic [W-1:0] Q;
    logic         RCO;
    logic         TICK;

    int m_val  = 0;
    bit m_last = 1'b1;
    int sb_q[$];
    int n_cmp  = 0;
    int n_bad  = 0;

    ttl_74161_chain_sync #(.STAGES(STAGES)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Cen   (Cen),
        .CLRn  (CLRn),
        .LOADn (LOADn),
        .ENP   (ENP),
        .ENT   (ENT),
        .D     (D),
        .Q     (Q),
        .RCO   (RCO),
        .TICK  (TICK)
    );

    always #5 Clk = ~Clk;

    // Drive one Clk worth of inputs; the model commits at the same posedge as the DUT
    task automatic cyc(input bit cen, input bit clrn, input bit loadn,
                       input bit enp, input bit ent_i, input int d);
        int  nv;
        bit  dev_edge;
        bit  push;
        Cen   = cen;
        CLRn  = clrn;
        LOADn = loadn;
        ENP   = enp;
        ENT   = ent_i;
        D     = W'(d);
        dev_edge = cen && !m_last;
        m_last   = cen;
        nv   = m_val;
        push = 1'b0;
        if (!clrn) begin
            nv = 0;
        end else if (dev_edge) begin
            if (!loadn)            nv = d % MODV;
            else if (enp && ent_i) nv = (m_val + 1) % MODV;
            push = 1'b1;
        end
        @(posedge Clk);
        m_val = nv;
        if (push) sb_q.push_back(nv);
        #2;
    endtask

    // Monitor: per-cycle state check plus TICK-driven scoreboard pop
    always @(negedge Clk) begin
        bit exp_rco;
        int e;
        n_cmp++;
        if (Q !== W'(m_val)) begin
            n_bad++;
            $display("FAIL q_state t=%0t got=%h want=%h", $time, Q, W'(m_val));
        end
        exp_rco = (ENT === 1'b1) && (m_val == MODV - 1);
        n_cmp++;
        if (RCO !== exp_rco) begin
            n_bad++;
            $display("FAIL rco t=%0t got=%b want=%b (q=%h ent=%b)", $time, RCO, exp_rco, Q, ENT);
        end
        if (TICK === 1'b1) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_bad++;
                $display("FAIL tick_unexpected t=%0t got=1 want=0", $time);
            end else begin
                e = sb_q.pop_front();
                if (Q !== W'(e)) begin
                    n_bad++;
                    $display("FAIL tick_q t=%0t got=%h want=%h", $time, Q, W'(e));
                end
            end
        end else if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            e = sb_q.pop_front();
            $display("FAIL tick_missing t=%0t got=%b want=1 (q_exp=%h)", $time, TICK, W'(e));
        end
    end

    initial begin
        Reset = 1'b1;
        Cen   = 1'b1;
        CLRn  = 1'b1;
        LOADn = 1'b1;
        ENP   = 1'b1;
        ENT   = 1'b0;
        D     = '0;
        repeat (2) @(posedge Clk);
        #2;
        Reset = 1'b0;

        // Cen held high from reset: no edge
        repeat (10) cyc(1, 1, 1, 1, 0, 0);

        // Full count through wrap with Cen toggling
        for (int i = 0; i < 512; i++) cyc((i % 2) == 1, 1, 1, 1, 1, 0);

        // Load 0E, then cross the nibble boundary
        cyc(0, 1, 1, 1, 1, 0);
        cyc(1, 1, 0, 1, 1, 8'h0E);
        for (int i = 0; i < 2; i++) begin
            cyc(0, 1, 1, 1, 1, 0);
            cyc(1, 1, 1, 1, 1, 0);
        end

        // Clear between edges at 37
        cyc(0, 1, 1, 1, 1, 0);
        cyc(1, 1, 0, 1, 1, 8'h37);
        cyc(0, 0, 1, 1, 1, 0);
        cyc(0, 1, 1, 1, 1, 0);
        // Clear held low across a Cen edge
        cyc(1, 0, 1, 1, 1, 0);
        cyc(0, 1, 1, 1, 1, 0);

        // Hold at FF with ENP low, then drop ENT
        cyc(1, 1, 0, 0, 1, 8'hFF);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 1, 0, 1, 0);
            cyc(1, 1, 1, 0, 1, 0);
        end
        cyc(0, 1, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 1, 0);

        // Async reset mid-cycle at A5
        cyc(1, 1, 0, 1, 1, 8'hA5);
        @(negedge Clk);
        #1;
        Reset = 1'b1;
        #1;
        n_cmp++;
        if (Q !== '0) begin
            n_bad++;
            $display("FAIL async_reset got=%h want=00", Q);
        end
        m_val  = 0;
        m_last = 1'b1;
        sb_q.delete();
        @(posedge Clk);
        #2;
        Reset = 1'b0;
        repeat (3) cyc(1, 1, 1, 1, 1, 0);
        for (int i = 0; i < 8; i++) cyc((i % 2) == 1, 1, 1, 1, 1, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            cyc(1'($urandom_range(0, 1)),
                $urandom_range(0, 15) != 0,
                $urandom_range(0, 7) != 0,
                1'($urandom_range(0, 1)),
                $urandom_range(0, 3) != 0,
                int'($urandom_range(0, MODV - 1)));
        end

        @(negedge Clk);
        #1;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL sb_leftover got=%0d want=0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
